// File: rtl/mds_seq.sv
// Sequential Twofish MDS multiply: folds COLS_PER_CYCLE matrix columns per clock into XOR accumulators.
// Optional build macro MDS_LE_OUT_EN packs out_data little-endian ({z3,z2,z1,z0}).
module mds_seq #(
   parameter logic [8:0] POLY           = 9'h169,
   parameter int         COLS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  y0,
   input  logic [7:0]  y1,
   input  logic [7:0]  y2,
   input  logic [7:0]  y3,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);

   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
         $error("mds_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
      if (POLY[8] != 1'b1) begin : g_bad_poly
         $error("mds_seq: POLY bit 8 must be set");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [1:0]  col;
   logic [7:0]  y_reg    [4];
   logic [7:0]  acc_reg  [4];
   logic [7:0]  acc_next [4];
   logic        last_chunk;
   logic [31:0] packed_next;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] p;
      logic [8:0] s;
      p = 9'd0;
      s = {1'b0, a};
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ s;
         s = s << 1;
         if (s[8]) s = s ^ POLY;
      end
      return p[7:0];
   endfunction

   function automatic logic [7:0] coef(input logic [1:0] r, input logic [1:0] c);
      logic [7:0] m;
      case ({r, c})
         4'h0: m = 8'h01;  4'h1: m = 8'hEF;  4'h2: m = 8'h5B;  4'h3: m = 8'h5B;
         4'h4: m = 8'h5B;  4'h5: m = 8'hEF;  4'h6: m = 8'hEF;  4'h7: m = 8'h01;
         4'h8: m = 8'hEF;  4'h9: m = 8'h5B;  4'hA: m = 8'h01;  4'hB: m = 8'hEF;
         default: begin
            case (c)
               2'd0:    m = 8'hEF;
               2'd1:    m = 8'h01;
               2'd2:    m = 8'hEF;
               default: m = 8'h5B;
            endcase
         end
      endcase
      return m;
   endfunction

   always_comb begin : acc_calc
      logic [1:0] idx;
      idx = col;
      for (int r = 0; r < 4; r++) acc_next[r] = acc_reg[r];
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         idx = col + 2'(j);
         for (int r = 0; r < 4; r++) begin
            acc_next[r] = acc_next[r] ^ gf_mul(coef(2'(r), idx), y_reg[idx]);
         end
      end
   end

   assign last_chunk = (({1'b0, col} + 3'(COLS_PER_CYCLE)) == 3'd4);

`ifdef MDS_LE_OUT_EN
   assign packed_next = {acc_next[3], acc_next[2], acc_next[1], acc_next[0]};
`else
   assign packed_next = {acc_next[0], acc_next[1], acc_next[2], acc_next[3]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         col       <= 2'd0;
         out_valid <= 1'b0;
         out_data  <= 32'd0;
         for (int i = 0; i < 4; i++) begin
            acc_reg[i] <= 8'd0;
            y_reg[i]   <= 8'd0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  y_reg[0] <= y0;
                  y_reg[1] <= y1;
                  y_reg[2] <= y2;
                  y_reg[3] <= y3;
                  for (int i = 0; i < 4; i++) acc_reg[i] <= 8'd0;
                  col   <= 2'd0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               for (int i = 0; i < 4; i++) acc_reg[i] <= acc_next[i];
               if (last_chunk) begin
                  // Result is taken from acc_next so the final chunk costs no extra cycle.
                  out_data  <= packed_next;
                  out_valid <= 1'b1;
                  col       <= 2'd0;
                  state     <= DONE;
               end else begin
                  col <= col + 2'(COLS_PER_CYCLE);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state == BUSY);

endmodule

// File: tb/tb_mds_seq.sv
// Directed bench for mds_seq: three instances (1, 2 and 4 columns per cycle) run the same vectors.
module tb_mds_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a       [3];
   logic        in_valid_a  [3];
   logic        in_ready_a  [3];
   logic [7:0]  y0_a        [3];
   logic [7:0]  y1_a        [3];
   logic [7:0]  y2_a        [3];
   logic [7:0]  y3_a        [3];
   logic        out_valid_a [3];
   logic        out_ready_a [3];
   logic [31:0] out_data_a  [3];
   logic        busy_a      [3];

   int checks = 0;
   int errors = 0;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         mds_seq #(
            .POLY(9'h169),
            .COLS_PER_CYCLE(gi == 0 ? 1 : (gi == 1 ? 2 : 4))
         ) u_dut (
            .clk(clk),
            .rst(rst_a[gi]),
            .in_valid(in_valid_a[gi]),
            .in_ready(in_ready_a[gi]),
            .y0(y0_a[gi]),
            .y1(y1_a[gi]),
            .y2(y2_a[gi]),
            .y3(y3_a[gi]),
            .out_valid(out_valid_a[gi]),
            .out_ready(out_ready_a[gi]),
            .out_data(out_data_a[gi]),
            .busy(busy_a[gi])
         );
      end
   endgenerate

   function automatic logic [31:0] fix(input logic [31:0] w);
`ifdef MDS_LE_OUT_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 5 : ((k == 1) ? 3 : 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_vec(input int k, input logic [31:0] yin, input logic [31:0] exp,
                          input int hold, input string name);
      int n;
      @(negedge clk);
      chk($sformatf("%s_k%0d_in_ready_idle", name, k), 32'(in_ready_a[k]), 32'd1);
      {y0_a[k], y1_a[k], y2_a[k], y3_a[k]} = yin;
      in_valid_a[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      // Scramble inputs and keep in_valid high: neither may disturb the running word.
      {y0_a[k], y1_a[k], y2_a[k], y3_a[k]} = $urandom;
      chk($sformatf("%s_k%0d_busy", name, k), 32'(busy_a[k]), 32'd1);
      n = 1;
      while (!out_valid_a[k] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("%s_k%0d_latency", name, k), 32'(n), 32'(lat_of(k)));
      chk($sformatf("%s_k%0d_data", name, k), out_data_a[k], fix(exp));
      chk($sformatf("%s_k%0d_in_ready_done", name, k), 32'(in_ready_a[k]), 32'd0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk($sformatf("%s_k%0d_hold_valid", name, k), 32'(out_valid_a[k]), 32'd1);
         chk($sformatf("%s_k%0d_hold_data", name, k), out_data_a[k], fix(exp));
         chk($sformatf("%s_k%0d_hold_in_ready", name, k), 32'(in_ready_a[k]), 32'd0);
      end
      in_valid_a[k]  = 1'b0;
      out_ready_a[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready_a[k] = 1'b0;
      chk($sformatf("%s_k%0d_valid_drop", name, k), 32'(out_valid_a[k]), 32'd0);
      chk($sformatf("%s_k%0d_in_ready_back", name, k), 32'(in_ready_a[k]), 32'd1);
      $display("TXN k=%0d %s y=%h out=%h latency=%0d hold=%0d", k, name, yin, out_data_a[k], n, hold);
   endtask

   task automatic rst_test(input int k);
      @(negedge clk);
      {y0_a[k], y1_a[k], y2_a[k], y3_a[k]} = 32'h01000000;
      in_valid_a[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_a[k] = 1'b0;
      @(negedge clk);
      rst_a[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_a[k] = 1'b0;
      chk($sformatf("rst_mid_k%0d_valid", k), 32'(out_valid_a[k]), 32'd0);
      chk($sformatf("rst_mid_k%0d_data", k), out_data_a[k], 32'd0);
      chk($sformatf("rst_mid_k%0d_in_ready", k), 32'(in_ready_a[k]), 32'd1);
      chk($sformatf("rst_mid_k%0d_busy", k), 32'(busy_a[k]), 32'd0);
      $display("TXN k=%0d mid-operation reset applied", k);
   endtask

   logic [31:0] vin  [7];
   logic [31:0] vexp [7];

   initial begin
      vin[0] = 32'h01000000; vexp[0] = 32'h015BEFEF;
      vin[1] = 32'h00010000; vexp[1] = 32'hEFEF5B01;
      vin[2] = 32'h01010000; vexp[2] = 32'hEEB4B4EE;
      vin[3] = 32'h02000000; vexp[3] = 32'h02B6B7B7;
      vin[4] = 32'h00000000; vexp[4] = 32'h00000000;
      vin[5] = 32'h00000100; vexp[5] = 32'h5BEF01EF;
      vin[6] = 32'h00000001; vexp[6] = 32'h5B01EF5B;

      for (int k = 0; k < 3; k++) begin
         rst_a[k]       = 1'b1;
         in_valid_a[k]  = 1'b1;
         out_ready_a[k] = 1'b0;
         y0_a[k] = 8'hA5; y1_a[k] = 8'h5A; y2_a[k] = 8'h3C; y3_a[k] = 8'hC3;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_k%0d_valid", k), 32'(out_valid_a[k]), 32'd0);
         chk($sformatf("reset_k%0d_data", k), out_data_a[k], 32'd0);
         chk($sformatf("reset_k%0d_in_ready", k), 32'(in_ready_a[k]), 32'd1);
         chk($sformatf("reset_k%0d_busy", k), 32'(busy_a[k]), 32'd0);
         rst_a[k]      = 1'b0;
         in_valid_a[k] = 1'b0;
      end

      for (int k = 0; k < 3; k++) begin
         for (int v = 0; v < 7; v++) run_vec(k, vin[v], vexp[v], 0, $sformatf("vec%0d", v));
         run_vec(k, 32'h03000000, 32'h03ED5858, 10, "hold");
         rst_test(k);
         run_vec(k, 32'h01000000, 32'h015BEFEF, 0, "after_rst");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
